// File: rtl/mem_access_controller_if.sv
// Core-request and Avalon data-bus signals of the load/store controller.
// slave = the controller itself; master = its environment (core plus data memory).
interface mem_access_controller_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  opcode;
  logic [31:0] base;
  logic [15:0] imm;
  logic [31:0] store_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  modport slave (
    input  req_valid, opcode, base, imm, store_data, waitrequest, readdata,
    output req_ready, rsp_valid, rsp_data, rsp_err, address, read, write,
           byteenable, writedata
  );

  modport master (
    output req_valid, opcode, base, imm, store_data, waitrequest, readdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err, address, read, write,
           byteenable, writedata
  );
endinterface

// File: rtl/mem_access_controller.sv
// Sequences MIPS loads/stores onto an Avalon-style data bus with alignment
// checking, waitrequest timeout and sign/zero extension of load data.
module mem_access_controller #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_access_controller_if.slave  bus
);

  localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e             state_q, state_d;
  logic [5:0]         op_q, op_d;
  logic [1:0]         ea_lo_q, ea_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               read_q, read_d;
  logic               write_q, write_d;
  logic [31:0]        address_q, address_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [31:0]        rsp_data_q, rsp_data_d;

  logic [31:0]        ea_c;
  logic               legal_c;
  logic               is_byte_c, is_half_c, is_load_c;
  logic               misaligned_c;
  logic [7:0]         lane_b_c;
  logic [15:0]        lane_h_c;
  logic [31:0]        load_c;
  logic               timeout_c;

  // Decode the incoming request and compute its effective address.
  always_comb begin
    ea_c      = bus.base + {{16{bus.imm[15]}}, bus.imm};
    legal_c   = 1'b0;
    is_byte_c = 1'b0;
    is_half_c = 1'b0;
    case (bus.opcode)
      OP_LB, OP_LBU, OP_SB: begin legal_c = 1'b1; is_byte_c = 1'b1; end
      OP_LH, OP_LHU, OP_SH: begin legal_c = 1'b1; is_half_c = 1'b1; end
      OP_LW, OP_SW:         legal_c = 1'b1;
      default:              legal_c = 1'b0;
    endcase
    is_load_c    = ~bus.opcode[3];
    misaligned_c = is_half_c ? ea_c[0] : (!is_byte_c && (ea_c[1:0] != 2'b00));
  end

  // Pick the addressed lane of readdata and extend it for the latched opcode.
  always_comb begin
    case (ea_lo_q)
      2'd0:    lane_b_c = bus.readdata[7:0];
      2'd1:    lane_b_c = bus.readdata[15:8];
      2'd2:    lane_b_c = bus.readdata[23:16];
      default: lane_b_c = bus.readdata[31:24];
    endcase
    lane_h_c = ea_lo_q[1] ? bus.readdata[31:16] : bus.readdata[15:0];
    case (op_q)
      OP_LB:   load_c = {{24{lane_b_c[7]}}, lane_b_c};
      OP_LBU:  load_c = {24'h0, lane_b_c};
      OP_LH:   load_c = {{16{lane_h_c[15]}}, lane_h_c};
      OP_LHU:  load_c = {16'h0, lane_h_c};
      OP_LW:   load_c = bus.readdata;
      default: load_c = 32'h0;
    endcase
    timeout_c = (MAX_WAIT != 0) && (cnt_q == CNT_W'(MAX_WAIT - 1));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ea_lo_d     = ea_lo_q;
    cnt_d       = cnt_q;
    read_d      = read_q;
    write_d     = write_q;
    address_d   = address_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.opcode;
          ea_lo_d = ea_c[1:0];
          cnt_d   = '0;
          if (!legal_c || misaligned_c) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = 32'h0;
          end else begin
            state_d   = ACCESS;
            address_d = {ea_c[31:2], 2'b00};
            read_d    = is_load_c;
            write_d   = ~is_load_c;
            if (is_byte_c)      be_d = 4'b0001 << ea_c[1:0];
            else if (is_half_c) be_d = ea_c[1] ? 4'b1100 : 4'b0011;
            else                be_d = 4'b1111;
            if (is_load_c)      wdata_d = 32'h0;
            else if (is_byte_c) wdata_d = {4{bus.store_data[7:0]}};
            else if (is_half_c) wdata_d = {2{bus.store_data[15:0]}};
            else                wdata_d = bus.store_data;
          end
        end
      end
      ACCESS: begin
        if (!bus.waitrequest) begin
          state_d     = RESP;
          read_d      = 1'b0;
          write_d     = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = read_q ? load_c : 32'h0;
        end else if (timeout_c) begin
          state_d     = RESP;
          read_d      = 1'b0;
          write_d     = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = 32'h0;
        end else if (MAX_WAIT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= 6'h0;
      ea_lo_q     <= 2'b00;
      cnt_q       <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      address_q   <= 32'h0;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ea_lo_q     <= ea_lo_d;
      cnt_q       <= cnt_d;
      read_q      <= read_d;
      write_q     <= write_d;
      address_q   <= address_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.address    = address_q;
  assign bus.byteenable = be_q;
  assign bus.writedata  = wdata_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench for mem_access_controller: stimulus pushes expected responses,
// a negedge monitor pops and compares them; bus and latency checked per op.
module tb_mem_access_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_controller_if bus ();

  mem_access_controller #(.MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%08h required=%08h", nm, act, exp);
    end
  endtask

  // Response monitor: every rsp_valid must match the oldest expected response.
  always @(negedge clk) begin
    if (!reset && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_data", bus.rsp_data, mon_e.data);
        check("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
      end
    end
  end

  // exp_bus: 0 none, 1 read, 2 write.
  task automatic do_op(input string nm, input logic [5:0] op, input logic [31:0] b,
                       input logic [15:0] im, input logic [31:0] rt, input int nwait,
                       input logic [31:0] rd, input int exp_bus, input logic [31:0] exp_addr,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd,
                       input logic [31:0] exp_data, input logic exp_err,
                       input int exp_strb, input int exp_lat);
    int waits_done = 0;
    int strb = 0;
    int lat = -1;
    int guard = 0;
    bit first = 1'b1;
    exp_t e;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.opcode     = op;
    bus.base       = b;
    bus.imm        = im;
    bus.store_data = rt;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) check({nm, "_ready_timeout"}, 32'd0, 32'd1);
    e.data = exp_data;
    e.err  = exp_err;
    exp_q.push_back(e);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.opcode    = 6'h3F;
      bus.base      = 32'hX;
      if (bus.rsp_valid) begin
        lat = k;
        check({nm, "_strobe_drop"}, 32'(bus.read | bus.write), 32'd0);
        break;
      end
      if (bus.read || bus.write) begin
        strb++;
        if (first) begin
          first = 1'b0;
          check({nm, "_kind"}, {30'd0, bus.write, bus.read}, 32'(exp_bus));
          check({nm, "_addr"}, bus.address, exp_addr);
          check({nm, "_be"}, 32'(bus.byteenable), 32'(exp_be));
          if (exp_bus == 2) check({nm, "_wdata"}, bus.writedata, exp_wd);
        end
        bus.waitrequest = (waits_done < nwait);
        bus.readdata    = rd;
        waits_done++;
      end
    end
    bus.waitrequest = 1'b0;
    check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    check({nm, "_strobe_cycles"}, 32'(strb), 32'(exp_strb));
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.opcode      = 6'h0;
    bus.base        = 32'h0;
    bus.imm         = 16'h0;
    bus.store_data  = 32'h0;
    bus.waitrequest = 1'b0;
    bus.readdata    = 32'h0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_strobes", {30'd0, bus.write, bus.read}, 32'd0);
    check("rst_rsp", {30'd0, bus.rsp_err, bus.rsp_valid}, 32'd0);
    check("rst_addr", bus.address, 32'd0);
    check("rst_be", 32'(bus.byteenable), 32'd0);
    check("rst_wd", bus.writedata, 32'd0);
    check("rst_rdata", bus.rsp_data, 32'd0);
    reset = 1'b0;

    do_op("lw_basic", 6'h23, 32'h0000_1000, 16'hFFFC, 32'h0, 0, 32'hDEAD_BEEF,
          1, 32'h0000_0FFC, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0, 1, 2);
    do_op("lb_sign", 6'h20, 32'h0, 16'h0003, 32'h0, 0, 32'h80FF_FFFF,
          1, 32'h0, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0, 1, 2);
    do_op("lbu_zero", 6'h24, 32'h0, 16'h0003, 32'h0, 0, 32'h80FF_FFFF,
          1, 32'h0, 4'b1000, 32'h0, 32'h0000_0080, 1'b0, 1, 2);
    do_op("lb_lane1", 6'h20, 32'h0, 16'h0001, 32'h0, 0, 32'h0000_7F00,
          1, 32'h0, 4'b0010, 32'h0, 32'h0000_007F, 1'b0, 1, 2);
    do_op("sh_wait3", 6'h29, 32'h0, 16'h0002, 32'h1234_ABCD, 3, 32'h0,
          2, 32'h0, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0, 4, 5);
    do_op("lw_misalign", 6'h23, 32'h0, 16'h0002, 32'h0, 0, 32'h0,
          0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 0, 1);
    do_op("illegal_op", 6'h0F, 32'h0, 16'h0000, 32'h0, 0, 32'h0,
          0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 0, 1);
    do_op("lh_odd", 6'h21, 32'h1, 16'h0000, 32'h0, 0, 32'h0,
          0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 0, 1);
    do_op("lh_sign", 6'h21, 32'h0000_0100, 16'h0002, 32'h0, 0, 32'h8001_7FFF,
          1, 32'h0000_0100, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b0, 1, 2);
    do_op("lhu_wait1", 6'h25, 32'h0000_0100, 16'h0000, 32'h0, 1, 32'h8001_7FFF,
          1, 32'h0000_0100, 4'b0011, 32'h0, 32'h0000_7FFF, 1'b0, 2, 3);
    do_op("sb_negimm", 6'h28, 32'h0000_0020, 16'hFFFF, 32'h9999_995A, 0, 32'h0,
          2, 32'h0000_001C, 4'b1000, 32'h5A5A_5A5A, 32'h0, 1'b0, 1, 2);
    do_op("sw_basic", 6'h2B, 32'h0000_0040, 16'h0004, 32'hCAFE_F00D, 0, 32'h0,
          2, 32'h0000_0044, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0, 1, 2);
    do_op("ea_wrap", 6'h23, 32'hFFFF_FFFC, 16'h0008, 32'h0, 0, 32'h1357_9BDF,
          1, 32'h0000_0004, 4'b1111, 32'h0, 32'h1357_9BDF, 1'b0, 1, 2);
    do_op("timeout", 6'h23, 32'h0, 16'h0010, 32'h0, 100, 32'hFFFF_FFFF,
          1, 32'h0000_0010, 4'b1111, 32'h0, 32'h0, 1'b1, 4, 5);

    // Reset during ACCESS abandons the access with no response.
    @(negedge clk);
    bus.req_valid   = 1'b1;
    bus.opcode      = 6'h23;
    bus.base        = 32'h0000_0200;
    bus.imm         = 16'h0;
    bus.waitrequest = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rst_mid_read_active", 32'(bus.read), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_strobes", {30'd0, bus.write, bus.read}, 32'd0);
    check("rst_mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
    check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    bus.waitrequest = 1'b0;
    repeat (3) @(negedge clk);

    do_op("post_reset_lw", 6'h23, 32'h0000_0300, 16'h0004, 32'h0, 0, 32'h0BAD_F00D,
          1, 32'h0000_0304, 4'b1111, 32'h0, 32'h0BAD_F00D, 1'b0, 1, 2);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
